// File: rtl/onehot_decoder_seq_pkg.sv
// Shared definitions for the sequential one-hot decoder: mode encodings,
// controller states and the mode-to-state decode.
package onehot_decoder_seq_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_DIRECT = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    // The reserved encoding parks the block in idle.
    function automatic state_t mode_to_state(input logic [1:0] mode);
        state_t s;
        s = S_IDLE;
        case (mode)
            MODE_IDLE:   s = S_IDLE;
            MODE_DIRECT: s = S_DIRECT;
            MODE_SCAN:   s = S_SCAN;
            MODE_RSVD:   s = S_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2onehot.sv
// Combinational binary-to-one-hot converter: exactly one output bit set, at
// the position given by bin.
module bin2onehot #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] bin,
    output logic [OUT_W-1:0] onehot
);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/onehot_decoder_seq.sv
// Sequential one-hot decoder: registered one-hot output driven either by a
// handshaked binary select (DIRECT) or by a timed walk across all outputs (SCAN).
module onehot_decoder_seq
    import onehot_decoder_seq_pkg::*;
#(
    parameter  int SEL_W = 3,
    parameter  int PER_W = 8,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             sel_valid,
    output logic             sel_ready,
    input  logic [PER_W-1:0] period,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    state_t           state;
    state_t           next_state;
    logic [PER_W-1:0] cnt;
    logic             scan_adv;
    logic [SEL_W-1:0] dec_idx;
    logic [OUT_W-1:0] dec_y;

    assign sel_ready = en && (state == S_DIRECT);

    // dec_idx is the index y will show after this edge; state changes reset it to 0,
    // which also gives the SCAN entry value of y.
    always_comb begin
        next_state = mode_to_state(mode);
        scan_adv   = (cnt >= period);
        dec_idx    = '0;
        if (state == next_state) begin
            if (state == S_DIRECT) begin
                dec_idx = sel;
            end else if (state == S_SCAN) begin
                dec_idx = idx + SEL_W'(1);
            end
        end
    end

    bin2onehot #(
        .SEL_W (SEL_W)
    ) u_bin2onehot (
        .bin    (dec_idx),
        .onehot (dec_y)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            y       <= '0;
            y_valid <= 1'b0;
            idx     <= '0;
            cnt     <= '0;
            wrap    <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else begin
            state <= next_state;
            wrap  <= 1'b0;
            case (next_state)
                S_DIRECT: begin
                    if (state != S_DIRECT) begin
                        y       <= '0;
                        y_valid <= 1'b0;
                        idx     <= '0;
                        cnt     <= '0;
                    end else if (sel_valid) begin
                        y       <= dec_y;
                        y_valid <= 1'b1;
                        idx     <= dec_idx;
                    end
                end
                S_SCAN: begin
                    if (state != S_SCAN) begin
                        y       <= dec_y;
                        y_valid <= 1'b1;
                        idx     <= '0;
                        cnt     <= '0;
                    end else if (scan_adv) begin
                        // >= rather than == so a period lowered mid-dwell advances at once.
                        y    <= dec_y;
                        idx  <= dec_idx;
                        cnt  <= '0;
                        wrap <= &idx;
                    end else begin
                        cnt <= cnt + PER_W'(1);
                    end
                end
                default: begin
                    y       <= '0;
                    y_valid <= 1'b0;
                    idx     <= '0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule
